// File: rtl/ccff_stream_loader.sv
// Config-chain writer: serialises cfg words into ccff_head and
// returns the bits leaving ccff_tail as readback words.
//
// Ports:
//   prog_clk, reset      clock, sync active-high reset
//   start                begin a load (IDLE only)
//   cfg_data/valid/ready bitstream words in, MSB first
//   rb_data/valid/ready  readback words out, first bit in MSB
//   ccff_head/ccff_tail  serial chain data out/in
//   chain_en             chain shifts at the end of this cycle
//   busy, done           status; done is a one-cycle pulse
module ccff_stream_loader #(
   parameter int CHAIN_LEN = 128,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   input  logic              rb_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              chain_en,
   output logic              busy,
   output logic              done
);

   localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int R      = CHAIN_LEN - (NWORDS - 1) * WORD_W;
   localparam int BCW    = $clog2(CHAIN_LEN + 1);
   localparam int WCW    = $clog2(NWORDS + 1);
   localparam int XCW    = $clog2(WORD_W + 1);

   localparam logic [BCW-1:0] BIT_LAST  = BCW'(CHAIN_LEN);
   localparam logic [WCW-1:0] WORDS_N   = WCW'(NWORDS);
   localparam logic [WCW-1:0] WORD_FIN  = WCW'(NWORDS - 1);
   localparam logic [XCW-1:0] W_FULL    = XCW'(WORD_W);
   localparam logic [XCW-1:0] W_REM     = XCW'(R);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic [WORD_W-1:0] tx_sr;
   logic [XCW-1:0]    tx_cnt;
   logic [WORD_W-1:0] rx_sr;
   logic [XCW-1:0]    rx_cnt;
   logic [BCW-1:0]    bit_cnt;
   logic [WCW-1:0]    word_cnt;
   logic              rb_last;

   logic              last_bit;
   logic              rx_full;
   logic              shift_en;
   logic              accept;
   logic              rb_take;
   logic              rb_load;
   logic [WORD_W-1:0] rx_aligned;

   assign last_bit = (bit_cnt == BIT_LAST);
   // final word may be short: it is full once the last chain bit is in
   assign rx_full  = (rx_cnt != '0) && ((rx_cnt == W_FULL) || last_bit);
   assign shift_en = (state == S_LOAD) && (tx_cnt != '0) &&
                     !rx_full && !last_bit;

   assign cfg_ready = (state == S_LOAD) && (tx_cnt == '0) &&
                      (word_cnt != WORDS_N);
   assign accept    = cfg_ready && cfg_valid;

   assign rb_take    = rb_valid && rb_ready;
   // handover and reload may share an edge
   assign rb_load    = rx_full && (!rb_valid || rb_ready);
   // left-align a short final word, low bits become 0
   assign rx_aligned = rx_sr << (W_FULL - rx_cnt);

   assign chain_en  = shift_en;
   assign ccff_head = shift_en & tx_sr[WORD_W-1];
   assign busy      = (state == S_LOAD) || (state == S_DRAIN);
   assign done      = (state == S_DONE);

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (start) state_nx = S_LOAD;
         S_LOAD:  if (last_bit) state_nx = S_DRAIN;
         S_DRAIN: if (rb_last && rb_take && !rx_full) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge prog_clk) begin
      if (reset) begin
         state    <= S_IDLE;
         tx_sr    <= '0;
         tx_cnt   <= '0;
         rx_sr    <= '0;
         rx_cnt   <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
         rb_last  <= 1'b0;
         rb_data  <= '0;
         rb_valid <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && start) begin
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            rb_last  <= 1'b0;
         end else begin
            if (accept) begin
               tx_sr    <= cfg_data;
               tx_cnt   <= (word_cnt == WORD_FIN) ? W_REM : W_FULL;
               word_cnt <= word_cnt + 1'b1;
            end else if (shift_en) begin
               tx_sr  <= {tx_sr[WORD_W-2:0], 1'b0};
               tx_cnt <= tx_cnt - 1'b1;
            end

            if (shift_en) begin
               rx_sr   <= {rx_sr[WORD_W-2:0], ccff_tail};
               rx_cnt  <= rx_cnt + 1'b1;
               bit_cnt <= bit_cnt + 1'b1;
            end else if (rb_load) begin
               rb_data <= rx_aligned;
               rx_cnt  <= '0;
               rb_last <= last_bit;
            end

            if (rb_load) begin
               rb_valid <= 1'b1;
            end else if (rb_take) begin
               rb_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Bench for ccff_stream_loader: 20-bit chain model, directed and
// random loads checked against a bit-list reference model.
module tb_ccff_stream_loader;

   localparam int CL = 20;
   localparam int WW = 8;
   localparam int NW = 3;

   logic          prog_clk = 1'b0;
   logic          reset;
   logic          start;
   logic [WW-1:0] cfg_data;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [WW-1:0] rb_data;
   logic          rb_valid;
   logic          rb_ready = 1'b0;
   logic          ccff_head;
   logic          ccff_tail;
   logic          chain_en;
   logic          busy;
   logic          done;

   always #5 prog_clk = ~prog_clk;

   ccff_stream_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
      .prog_clk  (prog_clk),
      .reset     (reset),
      .start     (start),
      .cfg_data  (cfg_data),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .rb_data   (rb_data),
      .rb_valid  (rb_valid),
      .rb_ready  (rb_ready),
      .ccff_head (ccff_head),
      .ccff_tail (ccff_tail),
      .chain_en  (chain_en),
      .busy      (busy),
      .done      (done)
   );

   // the attached configuration chain
   logic [CL-1:0] chain;
   logic          chain_clr;
   always @(posedge prog_clk) begin
      if (chain_clr) chain <= '0;
      else if (chain_en) chain <= {chain[CL-2:0], ccff_head};
   end
   assign ccff_tail = chain[CL-1];

   // readback consumer: 0 stall, 1 always ready, 2 random
   int rb_mode = 1;
   always @(posedge prog_clk) begin
      #1;
      case (rb_mode)
         0:       rb_ready = 1'b0;
         1:       rb_ready = 1'b1;
         default: rb_ready = 1'($urandom_range(0, 1));
      endcase
   end

   bit            head_q[$];
   logic [WW-1:0] rb_q[$];
   int            done_cnt = 0;
   int            head_bad = 0;
   always @(negedge prog_clk) begin
      if (chain_en) head_q.push_back(ccff_head);
      else if (ccff_head) head_bad++;
      if (rb_valid && rb_ready) rb_q.push_back(rb_data);
      if (done) done_cnt++;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference model: bits in shift order
   logic [WW-1:0] words[NW];
   bit            cur_bits[CL];
   bit            prev_bits[CL];

   task automatic build_bits();
      for (int i = 0; i < CL; i++)
         cur_bits[i] = words[i / WW][WW - 1 - (i % WW)];
   endtask

   function automatic logic [WW-1:0] exp_rb(input int k);
      logic [WW-1:0] e;
      e = '0;
      for (int j = 0; j < WW; j++)
         if (k * WW + j < CL) e[WW - 1 - j] = prev_bits[k * WW + j];
      return e;
   endfunction

   task automatic pulse_start();
      @(posedge prog_clk); #1 start = 1'b1;
      @(posedge prog_clk); #1 start = 1'b0;
   endtask

   task automatic send(input logic [WW-1:0] w);
      bit got;
      got = 1'b0;
      cfg_data  = w;
      cfg_valid = 1'b1;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge prog_clk);
         if (cfg_ready) got = 1'b1;
      end
      if (!got) chk("cfg_accept_timeout", 32'd0, 32'd1);
      @(posedge prog_clk); #1 cfg_valid = 1'b0;
   endtask

   // mode: 0 plain, 1 rb backpressure, 2 source gaps, 3 random gaps
   task automatic do_load(input int mode, input string nm);
      int hb, rbb, db, hbad0, gbad, k;
      logic [CL-1:0] obs_v, exp_v;
      hb    = head_q.size();
      rbb   = rb_q.size();
      db    = done_cnt;
      hbad0 = head_bad;
      build_bits();
      pulse_start();
      chk({nm, "_busy_start"}, 32'(busy), 32'd1);
      for (int w = 0; w < NW; w++) begin
         if (mode == 3) begin
            repeat ($urandom_range(0, 3)) begin
               @(posedge prog_clk); #1;
            end
         end
         send(words[w]);
         if (mode == 2 && w < NW - 1) begin
            gbad = 0;
            repeat (8) @(posedge prog_clk);
            repeat (5) begin
               @(negedge prog_clk);
               if (chain_en) gbad++;
            end
            @(posedge prog_clk); #1;
            chk({nm, "_gap_chain_en"}, 32'(gbad), 32'd0);
         end
      end
      if (mode == 1) begin
         repeat (30) @(posedge prog_clk);
         #1;
         chk({nm, "_bp_shifts"}, 32'(head_q.size() - hb), 32'd16);
         chk({nm, "_bp_chain_en"}, 32'(chain_en), 32'd0);
         chk({nm, "_bp_rb_valid"}, 32'(rb_valid), 32'd1);
         chk({nm, "_bp_rb_data"}, 32'(rb_data), 32'(exp_rb(0)));
         repeat (5) @(posedge prog_clk);
         #1;
         chk({nm, "_bp_rb_hold"}, 32'(rb_data), 32'(exp_rb(0)));
         chk({nm, "_bp_shifts_hold"}, 32'(head_q.size() - hb), 32'd16);
         rb_mode = 1;
      end
      k = 0;
      while (done_cnt == db && k < 400) begin
         @(posedge prog_clk); #1;
         k++;
      end
      repeat (4) @(posedge prog_clk);
      #1;
      chk({nm, "_done_pulses"}, 32'(done_cnt - db), 32'd1);
      chk({nm, "_busy_end"}, 32'(busy), 32'd0);
      chk({nm, "_shifts"}, 32'(head_q.size() - hb), 32'(CL));
      obs_v = '0;
      exp_v = '0;
      for (int i = 0; i < CL; i++) begin
         if (hb + i < head_q.size()) obs_v[CL - 1 - i] = head_q[hb + i];
         exp_v[CL - 1 - i] = cur_bits[i];
      end
      chk({nm, "_head_seq"}, 32'(obs_v), 32'(exp_v));
      chk({nm, "_chain"}, 32'(chain), 32'(exp_v));
      chk({nm, "_head_idle0"}, 32'(head_bad - hbad0), 32'd0);
      chk({nm, "_rb_count"}, 32'(rb_q.size() - rbb), 32'(NW));
      for (int w = 0; w < NW; w++) begin
         if (rbb + w < rb_q.size())
            chk({nm, "_rb_word"}, 32'(rb_q[rbb + w]), 32'(exp_rb(w)));
      end
      prev_bits = cur_bits;
   endtask

   initial begin
      int db, hb, k;
      reset     = 1'b1;
      chain_clr = 1'b1;
      start     = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = '0;
      for (int i = 0; i < CL; i++) prev_bits[i] = 1'b0;
      repeat (2) @(posedge prog_clk);
      #1;
      reset     = 1'b0;
      chain_clr = 1'b0;
      @(negedge prog_clk);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("rst_rb_valid", 32'(rb_valid), 32'd0);
      chk("rst_rb_data", 32'(rb_data), 32'd0);
      chk("rst_ccff_head", 32'(ccff_head), 32'd0);
      chk("rst_chain_en", 32'(chain_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      cfg_valid = 1'b1;
      repeat (3) begin
         @(negedge prog_clk);
         chk("idle_cfg_ready", 32'(cfg_ready), 32'd0);
      end
      @(posedge prog_clk); #1 cfg_valid = 1'b0;

      words = '{8'hA5, 8'h3C, 8'hF0};
      do_load(0, "basic");
      words = '{8'h00, 8'h00, 8'h00};
      do_load(0, "readback");
      rb_mode = 0;
      words = '{8'hA5, 8'h3C, 8'hF0};
      do_load(1, "backpressure");
      do_load(2, "gaps");

      // abort after 10 shifts, with a stray start mid-load
      rb_mode = 1;
      words = '{8'h5A, 8'hC3, 8'h99};
      db = done_cnt;
      hb = head_q.size();
      pulse_start();
      send(words[0]);
      pulse_start();
      send(words[1]);
      k = 0;
      while (head_q.size() - hb < 10 && k < 200) begin
         @(posedge prog_clk); #1;
         k++;
      end
      chk("abort_busy_before", 32'(busy), 32'd1);
      reset     = 1'b1;
      chain_clr = 1'b1;
      @(posedge prog_clk); #1;
      reset     = 1'b0;
      chain_clr = 1'b0;
      @(negedge prog_clk);
      chk("abort_chain_en", 32'(chain_en), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_cfg_ready", 32'(cfg_ready), 32'd0);
      repeat (5) @(posedge prog_clk);
      #1;
      chk("abort_no_done", 32'(done_cnt - db), 32'd0);
      for (int i = 0; i < CL; i++) prev_bits[i] = 1'b0;
      words = '{8'hA5, 8'h3C, 8'hF0};
      do_load(0, "fresh");

      rb_mode = 2;
      for (int r = 0; r < 4; r++) begin
         for (int w = 0; w < NW; w++) words[w] = WW'($urandom);
         do_load(3, "random");
      end
      rb_mode = 1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
